custom_vec_mem: RTL



---
 rtl/custom_vec_mem_if.sv | 28 ++
 rtl/custom_vec_mem.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/custom_vec_mem_if.sv
// Request/grant bus for custom_vec_mem: NrReadPorts read ports plus one byte-enabled write port.
// Signal suffixes are named from the memory's side (slave): _i flows into the memory, _o flows out.
interface custom_vec_mem_if #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NrReadPorts = 2,
  parameter int unsigned AddrW       = 9
);
  logic [NrReadPorts-1:0]            rd_req_i;
  logic [NrReadPorts-1:0][AddrW-1:0] rd_addr_i;
  logic [NrReadPorts-1:0]            rd_gnt_o;
  logic [NrReadPorts-1:0]            rd_rvalid_o;
  logic [NrReadPorts-1:0][XLEN-1:0]  rd_rdata_o;
  logic                              wr_req_i;
  logic [AddrW-1:0]                  wr_addr_i;
  logic [XLEN-1:0]                   wr_data_i;
  logic [XLEN/8-1:0]                 wr_be_i;
  logic                              wr_gnt_o;

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i,
    input  rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i,
    output rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o
  );
endinterface

// File: rtl/custom_vec_mem.sv
// Banked multi-port vector scratch memory with zero-init sweep and per-bank read arbitration.
// Define CUSTOM_VEC_MEM_OUT_REG_EN to add an output register stage on read data/valid.
module custom_vec_mem #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NumWords    = 512,
  parameter int unsigned NrBanks     = 4,
  parameter int unsigned NrReadPorts = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  output logic            busy_o,
  custom_vec_mem_if.slave bus
);

  localparam int unsigned AddrW   = $clog2(NumWords);
  localparam int unsigned Rows    = NumWords / NrBanks;
  localparam int unsigned BankSh  = $clog2(NrBanks);
  localparam int unsigned BankW   = (NrBanks > 1) ? BankSh : 1;
  localparam int unsigned RowW    = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned RrW     = (NrReadPorts > 1) ? $clog2(NrReadPorts) : 1;
  localparam int unsigned NrBytes = XLEN / 8;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  function automatic logic [BankW-1:0] bank_of(input logic [AddrW-1:0] a);
    return BankW'(a & AddrW'(NrBanks - 1));
  endfunction

  function automatic logic [RowW-1:0] row_of(input logic [AddrW-1:0] a);
    return RowW'(a >> BankSh);
  endfunction

  logic [0:0]      state_q, state_d;
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic [RrW-1:0]  rr_q, rr_d;
  logic            run;

  logic [XLEN-1:0] mem_q [NrBanks][Rows];

  logic [NrReadPorts-1:0]           rvalid_q;
  logic [NrReadPorts-1:0][XLEN-1:0] rdata_q;

  logic                   wr_gnt;
  logic [BankW-1:0]       wbank;
  logic [RowW-1:0]        wrow;
  logic [NrReadPorts-1:0] cand, rd_gnt, stall;
  logic [BankW-1:0]       pbank    [NrReadPorts];
  logic [RowW-1:0]        prow     [NrReadPorts];
  logic                   win_found[NrBanks];
  logic [RrW-1:0]         win_port [NrBanks];

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      StInit: begin
        if (init_i) begin
          row_cnt_d = '0;
        end else if (row_cnt_q == RowW'(Rows - 1)) begin
          state_d   = StRun;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + RowW'(1);
        end
      end
      default: begin
        if (init_i) begin
          state_d   = StInit;
          row_cnt_d = '0;
        end
      end
    endcase
  end

  assign run    = (state_q == StRun);
  assign busy_o = (state_q == StInit);

  // ---------------------------------------------------------------- request decode
  always_comb begin
    wr_gnt = run & bus.wr_req_i;
    wbank  = bank_of(bus.wr_addr_i);
    wrow   = row_of(bus.wr_addr_i);
    for (int unsigned p = 0; p < NrReadPorts; p++) begin
      pbank[p] = bank_of(bus.rd_addr_i[p]);
      prow[p]  = row_of(bus.rd_addr_i[p]);
      cand[p]  = run & bus.rd_req_i[p] & ~(wr_gnt & (pbank[p] == wbank));
    end
  end

  // ---------------------------------------------------------------- per-bank winner search
  always_comb begin
    logic [RrW-1:0] idx;
    idx = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      win_found[b] = 1'b0;
      win_port[b]  = '0;
    end
    for (int unsigned k = 0; k < NrReadPorts; k++) begin
      idx = RrW'((32'(rr_q) + k) % NrReadPorts);
      if (cand[idx] && !win_found[pbank[idx]]) begin
        win_found[pbank[idx]] = 1'b1;
        win_port[pbank[idx]]  = idx;
      end
    end
  end

  // ---------------------------------------------------------------- grants and round-robin update
  always_comb begin
    logic upd;
    upd  = 1'b0;
    rr_d = rr_q;
    for (int unsigned p = 0; p < NrReadPorts; p++) begin
      rd_gnt[p] = cand[p] & (bus.rd_addr_i[p] == bus.rd_addr_i[win_port[pbank[p]]]);
      stall[p]  = cand[p] & ~rd_gnt[p];
    end
    // With several conflicting banks in one cycle the lowest-numbered bank steers rr_q.
    for (int unsigned b = 0; b < NrBanks; b++) begin
      for (int unsigned p = 0; p < NrReadPorts; p++) begin
        if (!upd && stall[p] && (pbank[p] == BankW'(b))) begin
          upd  = 1'b1;
          rr_d = RrW'((32'(win_port[b]) + 1) % NrReadPorts);
        end
      end
    end
  end

  assign bus.rd_gnt_o = rd_gnt;
  assign bus.wr_gnt_o = wr_gnt;

  // ---------------------------------------------------------------- state and read pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StInit;
      row_cnt_q <= '0;
      rr_q      <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      rr_q      <= rr_d;
      rvalid_q  <= rd_gnt;
      for (int unsigned p = 0; p < NrReadPorts; p++) begin
        if (rd_gnt[p]) begin
          rdata_q[p] <= mem_q[pbank[p]][prow[p]];
        end
      end
    end
  end

  // ---------------------------------------------------------------- storage array
  always_ff @(posedge clk_i) begin
    if (!run) begin
      for (int unsigned b = 0; b < NrBanks; b++) begin
        mem_q[b][row_cnt_q] <= '0;
      end
    end else if (wr_gnt) begin
      for (int unsigned i = 0; i < NrBytes; i++) begin
        if (bus.wr_be_i[i]) begin
          mem_q[wbank][wrow][8*i +: 8] <= bus.wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- output stage
`ifdef CUSTOM_VEC_MEM_OUT_REG_EN
  logic [NrReadPorts-1:0]           out_rvalid_q;
  logic [NrReadPorts-1:0][XLEN-1:0] out_rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_rvalid_q <= '0;
      out_rdata_q  <= '0;
    end else begin
      out_rvalid_q <= rvalid_q;
      for (int unsigned p = 0; p < NrReadPorts; p++) begin
        if (rvalid_q[p]) begin
          out_rdata_q[p] <= rdata_q[p];
        end
      end
    end
  end

  assign bus.rd_rvalid_o = out_rvalid_q;
  assign bus.rd_rdata_o  = out_rdata_q;
`else
  assign bus.rd_rvalid_o = rvalid_q;
  assign bus.rd_rdata_o  = rdata_q;
`endif

endmodule
